// File: rtl/mema_seq_ctrl.sv
// mema_seq_ctrl: sequencer for the skewed A-operand FIFO bank.
// Each job loads DIM host row vectors into the bank (LOAD), then pulses the
// bank shift enable for SHIFT_CYCLES non-stalled cycles (SHIFT).
// Optional perf counter of stalled SHIFT cycles: define MEMA_SEQ_CTRL_PERF_EN.
module mema_seq_ctrl #(
  parameter int BITS_AB      = 8,
  parameter int DIM          = 8,
  parameter int SHIFT_CYCLES = 3*DIM-2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  in_data,
  input  logic                                stall,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  output logic                                WrEn,
  output logic [$clog2(DIM)-1:0]              Arow,
  output logic                                en,
  output logic                                busy,
  output logic                                done,
  output logic [31:0]                         stall_cycles
);

  localparam int RW = $clog2(DIM);
  localparam int SW = $clog2(SHIFT_CYCLES+1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(DIM-1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CYCLES-1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
  logic            done_q, done_d;

  // State, counters and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      shift_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      done_q      <= done_d;
    end
  end

  // Next state: row_cnt is cleared when LOAD ends so Arow reads 0 outside LOAD
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    shift_cnt_d = shift_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          row_cnt_d   = '0;
          shift_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (row_cnt_q == ROW_LAST) begin
            state_d   = SHIFT;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (shift_cnt_q == SHIFT_LAST) begin
            state_d     = IDLE;
            shift_cnt_d = '0;
            done_d      = 1'b1;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write path is a zero-latency pass-through of the accepted beat
  always_comb begin
    in_ready = (state_q == LOAD);
    WrEn     = (state_q == LOAD) && in_valid;
    en       = (state_q == SHIFT) && !stall;
    busy     = (state_q != IDLE);
    done     = done_q;
    Arow     = row_cnt_q;
    Ain      = in_data;
  end

`ifdef MEMA_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled SHIFT cycles, restarted by each accepted start
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_q == IDLE && start)
      stall_cycles_d = '0;
    else if (state_q == SHIFT && stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Perf counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
